bist_sequencer: RTL
===================

# bist_sequencer

Hardware built-in self-test sequencer that launches a fixed list of sub-test engines one at a time, waits for each to report completion, sums their error counts, and produces one pass/fail verdict. A per-test watchdog aborts a hung sub-test and stops the run. It sits beside the DAC/ADC/PWL datapaths, and its verdict is exposed through the AXI slave register map.

## Interface
Parameters:
- NUM_TESTS, 10, number of sub-test engines (1–32)
- ERR_WIDTH, 16, width of each per-test error count
- TOTAL_WIDTH, 32, width of the aggregate error total
- TIMEOUT, 1000, watchdog limit in clk cycles per test (≥2)

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a run.
- test_start  out  NUM_TESTS  one-hot, single-cycle launch pulse to sub-test i.
- test_done  in  NUM_TESTS  completion pulse from sub-test i.
- test_err  in  NUM_TESTS*ERR_WIDTH  flattened error counts; slice i is valid while test_done[i] is high.
- busy  out  1  a run is in progress.
- run_done  out  1  single-cycle pulse when a run ends.
- pass  out  1  result of the last run: total_errors == 0.
- total_errors  out  TOTAL_WIDTH  saturating sum of errors from the last run.
- timed_out  out  1  the last run was ended by the watchdog.
- cur_test  out  $clog2(NUM_TESTS)  index of the active sub-test, or the one that timed out.

## Operation
- Reset values: test_start=0, busy=0, run_done=0, pass=0, total_errors=0, timed_out=0, cur_test=0, FSM state=IDLE.
- IDLE:
  - start=1 → clear total_errors, timed_out and pass; set cur_test=0.
  - Go to LAUNCH.
- LAUNCH: drive test_start[cur_test]=1 for exactly one cycle, clear the watchdog, go to WAIT.
- WAIT: the watchdog increments every cycle.
  - test_done[cur_test]=1 → latch test_err slice cur_test, go to ACCUM.
  - Watchdog reaches TIMEOUT-1 without a done → add 1 to total_errors, set timed_out=1, go to FINISH. Remaining tests are not run.
  - test_done and watchdog expiry in the same cycle → done wins and no timeout is recorded.
  - test_done on any other index → ignored.
- ACCUM:
  - total_errors += latched count, saturating at 2^TOTAL_WIDTH−1.
  - If cur_test==NUM_TESTS-1 → FINISH; else cur_test++ and go to LAUNCH.
- FINISH: run_done=1 for one cycle, pass=(total_errors==0), go to IDLE.
- busy=1 in every state except IDLE.
- start while busy → ignored, not queued.
- Results hold until the next accepted start.
- rst asserted mid-run → all outputs return to reset values on the next edge. test_start is never left high.

## Timing
- start sampled at edge N → busy=1 and test_start[0]=1 from edge N+1.
- done sampled at edge M → total_errors updated at M+2; next test_start at M+2.
- Per-test overhead is 3 cycles (LAUNCH, WAIT exit, ACCUM) plus the sub-test latency.
- Final ACCUM at edge K → run_done and pass valid at K+1, busy=0 at K+2.
- Timeout:
  - Expiry is detected TIMEOUT cycles after the launch pulse.
  - timed_out and total_errors are updated on that edge.
  - run_done follows one cycle later.

## Configuration
- Macro BIST_SKIP_MASK_EN defined → adds input skip_mask [NUM_TESTS].
  - Tests whose bit is 1 are never launched and contribute 0 errors.
  - The skip is decided in ACCUM/IDLE, so skipped tests cost no cycles beyond the index step.
  - An all-ones mask goes start → FINISH with pass=1.
- Macro undefined → no port; all tests always run.

## Structure
- Package bist_pkg:
  - state enum {IDLE, LAUNCH, WAIT, ACCUM, FINISH}
  - default ERR_WIDTH/TOTAL_WIDTH constants
  - a saturating-add function
- Sub-module bist_watchdog: clear/enable inputs, expired output, TIMEOUT parameter. Reused by any future sequencer.

## Test plan
- NUM_TESTS=3; all tests report done after 5 cycles with 0 errors → run_done once, pass=1, total_errors=0, timed_out=0.
- Errors 2, 0, 7 → total_errors=9, pass=0. test_start pulses observed one-hot, each exactly 1 cycle.
- Test 1 never completes, TIMEOUT=20 → timed_out=1, cur_test=1, total_errors = test0 errors + 1, test_start[2] never asserted.
- TOTAL_WIDTH=8, errors 200 and 100 → total_errors=255. Test_done at watchdog expiry cycle 19 → no timeout recorded.
- rst mid-WAIT of test 1, then start again → outputs cleared, rerun begins at test 0. start pulsed while busy → no effect.
- With BIST_SKIP_MASK_EN, mask=3'b010 → test_start[1] never pulses, total equals tests 0 and 2 only.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared types and helpers for the BIST sequencer and its watchdog.
package bist_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWait,
    StAccum,
    StFinish
  } bist_state_e;

  localparam int unsigned DefaultErrWidth   = 16;
  localparam int unsigned DefaultTotalWidth = 32;

  // Unsigned add clamped to 2^width-1; operands must already fit in width bits.
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned width);
    logic [64:0] sum;
    logic [64:0] max;
    sum = {1'b0, a} + {1'b0, b};
    max = (65'(1) << width) - 65'(1);
    if (sum > max) return max[63:0];
    return sum[63:0];
  endfunction

endpackage

// File: rtl/bist_watchdog.sv
// Per-test watchdog: counts enabled cycles since clear, flags expiry at TIMEOUT-1.
module bist_watchdog #(
  parameter  int unsigned TIMEOUT = 1000,
  localparam int unsigned CntW    = $clog2(TIMEOUT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && (cnt_q == CntMax);

endmodule

// File: rtl/bist_sequencer.sv
// Runs sub-test engines in order, sums their error counts and reports pass/fail.
// Optional BIST_SKIP_MASK_EN adds a skip_mask input that bypasses selected tests.
module bist_sequencer
  import bist_pkg::*;
#(
  parameter  int unsigned NUM_TESTS   = 10,
  parameter  int unsigned ERR_WIDTH   = DefaultErrWidth,
  parameter  int unsigned TOTAL_WIDTH = DefaultTotalWidth,
  parameter  int unsigned TIMEOUT     = 1000,
  localparam int unsigned IdxW        = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic [NUM_TESTS-1:0]           test_start,
  input  logic [NUM_TESTS-1:0]           test_done,
  input  logic [NUM_TESTS*ERR_WIDTH-1:0] test_err,
`ifdef BIST_SKIP_MASK_EN
  input  logic [NUM_TESTS-1:0]           skip_mask,
`endif
  output logic                           busy,
  output logic                           run_done,
  output logic                           pass,
  output logic [TOTAL_WIDTH-1:0]         total_errors,
  output logic                           timed_out,
  output logic [IdxW-1:0]                cur_test
);

  bist_state_e            state_q, state_d;
  logic [IdxW-1:0]        cur_q, cur_d;
  logic [TOTAL_WIDTH-1:0] total_q, total_d;
  logic [ERR_WIDTH-1:0]   err_q, err_d;
  logic                   timed_out_q, timed_out_d;
  logic                   pass_q, pass_d;
  logic                   wd_expired;

  logic [IdxW-1:0] first_idx, next_idx;
  logic            first_ok, next_ok;

  bist_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q == StLaunch),
    .enable (state_q == StWait),
    .expired(wd_expired)
  );

`ifdef BIST_SKIP_MASK_EN
  // Lowest runnable index overall, and lowest runnable index above the current one.
  always_comb begin
    first_idx = '0;
    first_ok  = 1'b0;
    next_idx  = '0;
    next_ok   = 1'b0;
    for (int i = NUM_TESTS - 1; i >= 0; i--) begin
      if (!skip_mask[i]) begin
        first_idx = IdxW'(i);
        first_ok  = 1'b1;
        if (i > int'(cur_q)) begin
          next_idx = IdxW'(i);
          next_ok  = 1'b1;
        end
      end
    end
  end
`else
  assign first_idx = '0;
  assign first_ok  = 1'b1;
  assign next_idx  = cur_q + IdxW'(1);
  assign next_ok   = (cur_q != IdxW'(NUM_TESTS - 1));
`endif

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    total_d     = total_q;
    err_d       = err_q;
    timed_out_d = timed_out_q;
    pass_d      = pass_q;
    test_start  = '0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          total_d     = '0;
          timed_out_d = 1'b0;
          pass_d      = 1'b0;
          cur_d       = first_ok ? first_idx : '0;
          state_d     = first_ok ? StLaunch : StFinish;
        end
      end
      StLaunch: begin
        test_start[cur_q] = 1'b1;
        state_d           = StWait;
      end
      StWait: begin
        // A done arriving on the expiry cycle takes priority over the timeout.
        if (test_done[cur_q]) begin
          err_d   = test_err[cur_q*ERR_WIDTH +: ERR_WIDTH];
          state_d = StAccum;
        end else if (wd_expired) begin
          total_d     = TOTAL_WIDTH'(sat_add(64'(total_q), 64'(1), TOTAL_WIDTH));
          timed_out_d = 1'b1;
          state_d     = StFinish;
        end
      end
      StAccum: begin
        total_d = TOTAL_WIDTH'(sat_add(64'(total_q), 64'(err_q), TOTAL_WIDTH));
        if (next_ok) begin
          cur_d   = next_idx;
          state_d = StLaunch;
        end else begin
          state_d = StFinish;
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    // Verdict is registered on entry to FINISH so it is valid alongside run_done.
    if ((state_d == StFinish) && (state_q != StFinish)) begin
      pass_d = (total_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cur_q       <= '0;
      total_q     <= '0;
      err_q       <= '0;
      timed_out_q <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      total_q     <= total_d;
      err_q       <= err_d;
      timed_out_q <= timed_out_d;
      pass_q      <= pass_d;
    end
  end

  assign busy         = (state_q != StIdle);
  assign run_done     = (state_q == StFinish);
  assign pass         = pass_q;
  assign total_errors = total_q;
  assign timed_out    = timed_out_q;
  assign cur_test     = cur_q;

endmodule
